// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory-busy freeze.
// Optional bubble counter enabled by defining XGRISCV_HAZARD_CNT_EN.
module id_ex_pipe #(
    parameter int XLEN  = 32,
    parameter int RFIDX = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rd1,
    input  logic [XLEN-1:0]  id_rd2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RFIDX-1:0] id_rs1,
    input  logic [RFIDX-1:0] id_rs2,
    input  logic [RFIDX-1:0] id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [3:0]       id_aluctrl,
    input  logic [1:0]       id_alusrca,
    input  logic             id_alusrcb,
    input  logic             id_memwrite,
    input  logic             id_lunsigned,
    input  logic [1:0]       id_lwhb,
    input  logic [1:0]       id_swhb,
    input  logic             id_memtoreg,
    input  logic             id_regwrite,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rd1,
    output logic [XLEN-1:0]  ex_rd2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RFIDX-1:0] ex_rs1,
    output logic [RFIDX-1:0] ex_rs2,
    output logic [RFIDX-1:0] ex_rd,
    output logic [3:0]       ex_aluctrl,
    output logic [1:0]       ex_alusrca,
    output logic             ex_alusrcb,
    output logic             ex_memwrite,
    output logic             ex_lunsigned,
    output logic [1:0]       ex_lwhb,
    output logic [1:0]       ex_swhb,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic             stall,
    output logic [31:0]      hazard_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        HOLD_FL = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [RFIDX-1:0] rs1;
        logic [RFIDX-1:0] rs2;
        logic [RFIDX-1:0] rd;
        logic [3:0]       aluctrl;
        logic [1:0]       alusrca;
        logic             alusrcb;
        logic             memwrite;
        logic             lunsigned;
        logic [1:0]       lwhb;
        logic [1:0]       swhb;
        logic             memtoreg;
        logic             regwrite;
    } bundle_t;

    state_t  state_r, state_nxt_s;
    bundle_t ex_r, id_s;
    logic    lu_s, upd_s, ld_s, lu_bub_s;

    assign id_s = '{valid: id_valid, pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
                    rs1: id_rs1, rs2: id_rs2, rd: id_rd, aluctrl: id_aluctrl,
                    alusrca: id_alusrca, alusrcb: id_alusrcb, memwrite: id_memwrite,
                    lunsigned: id_lunsigned, lwhb: id_lwhb, swhb: id_swhb,
                    memtoreg: id_memtoreg, regwrite: id_regwrite};

    // A load in EX whose result the ID instruction needs; x0 is never a real dependency.
    assign lu_s = id_valid & ex_r.valid & ex_r.memtoreg & (ex_r.rd != {RFIDX{1'b0}}) &
                  ((id_uses_rs1 & (id_rs1 == ex_r.rd)) | (id_uses_rs2 & (id_rs2 == ex_r.rd)));

    assign stall = mem_busy | (state_r != RUN) | (lu_s & ~flush);

    // Next state and EX update action: upd_s loads EX, ld_s selects ID data over a bubble.
    always_comb begin
        state_nxt_s = state_r;
        upd_s       = 1'b0;
        ld_s        = 1'b0;
        lu_bub_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_busy) begin
                    state_nxt_s = flush ? HOLD_FL : HOLD;
                end else if (flush) begin
                    upd_s = 1'b1;
                end else if (lu_s) begin
                    upd_s    = 1'b1;
                    lu_bub_s = 1'b1;
                end else begin
                    upd_s = 1'b1;
                    ld_s  = id_valid;
                end
            end
            HOLD: begin
                if (mem_busy) begin
                    state_nxt_s = flush ? HOLD_FL : HOLD;
                end else begin
                    state_nxt_s = RUN;
                    upd_s       = 1'b1;
                    if (flush) begin
                        ld_s = 1'b0;
                    end else if (lu_s) begin
                        lu_bub_s = 1'b1;
                    end else begin
                        ld_s = id_valid;
                    end
                end
            end
            HOLD_FL: begin
                if (mem_busy) begin
                    state_nxt_s = HOLD_FL;
                end else begin
                    state_nxt_s = RUN;
                    upd_s       = 1'b1;
                end
            end
            default: begin
                state_nxt_s = RUN;
                upd_s       = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // EX bundle: loads ID data or a fully cleared bubble; holds while frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_r <= {$bits(bundle_t){1'b0}};
        end else if (upd_s) begin
            ex_r <= ld_s ? id_s : {$bits(bundle_t){1'b0}};
        end else begin
            ex_r <= ex_r;
        end
    end

    assign ex_valid     = ex_r.valid;
    assign ex_pc        = ex_r.pc;
    assign ex_rd1       = ex_r.rd1;
    assign ex_rd2       = ex_r.rd2;
    assign ex_imm       = ex_r.imm;
    assign ex_rs1       = ex_r.rs1;
    assign ex_rs2       = ex_r.rs2;
    assign ex_rd        = ex_r.rd;
    assign ex_aluctrl   = ex_r.aluctrl;
    assign ex_alusrca   = ex_r.alusrca;
    assign ex_alusrcb   = ex_r.alusrcb;
    assign ex_memwrite  = ex_r.memwrite;
    assign ex_lunsigned = ex_r.lunsigned;
    assign ex_lwhb      = ex_r.lwhb;
    assign ex_swhb      = ex_r.swhb;
    assign ex_memtoreg  = ex_r.memtoreg;
    assign ex_regwrite  = ex_r.regwrite;

`ifdef XGRISCV_HAZARD_CNT_EN
    logic [31:0] hazard_cnt_r;

    // Saturating count of load-use bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hazard_cnt_r <= 32'd0;
        end else if (lu_bub_s && (hazard_cnt_r != 32'hFFFF_FFFF)) begin
            hazard_cnt_r <= hazard_cnt_r + 32'd1;
        end else begin
            hazard_cnt_r <= hazard_cnt_r;
        end
    end

    assign hazard_cnt = hazard_cnt_r;
`else
    logic unused_lu_bub_s;
    assign unused_lu_bub_s = lu_bub_s;
    assign hazard_cnt      = 32'd0;
`endif

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register between the decode-stage controller/register-file read and the execute stage.
- Latches the controller's EX/MEM/WB control bundle and the decoded operands.
- Detects load-use hazards and inserts bubbles.
- Applies branch/jump flushes.
- Freezes when the memory stage is busy; a flush that arrives during a freeze is held as pending and applied once the freeze ends.

Parameters:
- XLEN, 32, datapath width of pc/operand/immediate fields
- RFIDX, 5, register index width (matches RFIDX_WIDTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_rd1  in  XLEN  rs1 read data
- id_rd2  in  XLEN  rs2 read data
- id_imm  in  XLEN  expanded immediate
- id_rs1  in  RFIDX  source index 1
- id_rs2  in  RFIDX  source index 2
- id_rd  in  RFIDX  destination index
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_aluctrl  in  4  ALU op from controller
- id_alusrca  in  2  ALU A select
- id_alusrcb  in  1  ALU B select
- id_memwrite  in  1  store
- id_lunsigned  in  1  unsigned load
- id_lwhb  in  2  load width code
- id_swhb  in  2  store width code
- id_memtoreg  in  1  load writeback
- id_regwrite  in  1  register write
- flush  in  1  redirect from branch/jump; kills ID instruction
- mem_busy  in  1  downstream not ready; freeze EX
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered copies of the id_* fields
- ex_rs1, ex_rs2, ex_rd  out  RFIDX  registered copies
- ex_aluctrl, ex_alusrca, ex_alusrcb, ex_memwrite, ex_lunsigned, ex_lwhb, ex_swhb, ex_memtoreg, ex_regwrite  out  as id_*  registered control
- stall  out  1  combinational; IF and IF/ID must hold
- hazard_cnt  out  32  bubble counter (optional feature)

Behaviour:
- Reset (reset=0, async): every ex_* output = 0 (ex_aluctrl = ALU_CTRL_ZERO = 0); state = RUN; hazard_cnt = 0.
- Latency: one cycle ID→EX.
- Load-use hazard (combinational):
  - lu = id_valid & ex_valid & ex_memtoreg & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- stall = mem_busy | (state != RUN) | (lu & ~flush).
- States:
  - RUN: normal operation.
  - HOLD: frozen, no pending flush.
  - HOLD_FL: frozen, flush pending.
- Transitions and per-cycle action, priority order:
  - RUN, mem_busy=1: EX registers hold. Next state = HOLD_FL if flush else HOLD.
  - RUN, mem_busy=0, flush=1: load bubble; stay RUN.
  - RUN, mem_busy=0, lu=1: load bubble; stay RUN. ID is held by stall and re-presents next cycle.
  - RUN, otherwise: load id_*; ex_valid <= id_valid.
  - HOLD, mem_busy=1: hold. flush=1 → HOLD_FL.
  - HOLD, mem_busy=0: load bubble if flush, otherwise load id_* (evaluating lu as in RUN). Next = RUN.
  - HOLD_FL, mem_busy=1: hold.
  - HOLD_FL, mem_busy=0: load bubble; next = RUN.
- Bubble: ex_valid=0 and all control outputs 0 (memwrite=0, regwrite=0, memtoreg=0, aluctrl=0). Data/index fields are also cleared to 0 for determinism.
- id_valid=0 loads are treated as bubbles (all controls 0).
- ex_rd=0 never triggers lu.
- A flush cancels lu in the same cycle: no stall is raised, because the ID instruction is dead.
- Reset asserted mid-freeze returns to RUN with a bubble in EX.

Optional Feature:
- XGRISCV_HAZARD_CNT_EN defined:
  - hazard_cnt increments by 1 on each clock edge at which a bubble is loaded because of lu (not flush, not hold).
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- Not defined: hazard_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset: drive reset=0 mid-run → all ex_* = 0 immediately (async), stall=0 after release with mem_busy=0.
- Pass-through: id_valid=1, id_pc=0x100, id_aluctrl=ADD, id_regwrite=1, id_rd=5 → next cycle ex_pc=0x100, ex_rd=5, ex_regwrite=1, ex_valid=1.
- Load-use: EX holds lw x5 (memtoreg=1, rd=5); ID add x6,x5,x7 (uses_rs1, rs1=5):
  - stall=1 for one cycle; EX gets a bubble (ex_regwrite=0); next cycle the add loads; hazard_cnt=1 with XGRISCV_HAZARD_CNT_EN.
- x0 guard: EX lw x0, ID reads rs1=0 → stall=0, no bubble.
- Flush vs hazard: lu=1 and flush=1 in the same cycle → stall=0, bubble loaded, hazard_cnt unchanged.
- Freeze with pending flush: mem_busy=1 for 3 cycles, flush pulsed in cycle 2 → EX outputs constant for 3 cycles and stall=1 throughout; when mem_busy falls, a bubble is loaded (ex_valid=0) and the state returns to RUN.
